// File: rtl/multiplier_mac_pipe_if.sv
// Valid/ready bus for the pipelined multiply-accumulate unit: operand beats in, product and
// running-sum beats out.
interface multiplier_mac_pipe_if #(
  parameter int unsigned A_BIT_LEN       = 17,
  parameter int unsigned B_BIT_LEN       = 17,
  parameter int unsigned MUL_OUT_BIT_LEN = A_BIT_LEN + B_BIT_LEN,
  parameter int unsigned ACC_BIT_LEN     = MUL_OUT_BIT_LEN + 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [A_BIT_LEN-1:0]       A;
  logic [B_BIT_LEN-1:0]       B;
  logic                       a_signed;
  logic                       b_signed;
  logic                       acc_en;
  logic                       out_valid;
  logic                       out_ready;
  logic [MUL_OUT_BIT_LEN-1:0] P;
  logic [ACC_BIT_LEN-1:0]     ACC;
  logic                       acc_ovf;

  modport master (
    output in_valid, A, B, a_signed, b_signed, acc_en, out_ready,
    input  in_ready, out_valid, P, ACC, acc_ovf
  );

  modport slave (
    input  in_valid, A, B, a_signed, b_signed, acc_en, out_ready,
    output in_ready, out_valid, P, ACC, acc_ovf
  );

endinterface

// File: rtl/multiplier_mac_pipe.sv
// Pipelined multiplier / multiply-accumulate with per-operand signedness, global-stall
// valid/ready flow control and a sticky overflow flag on the running sum.
module multiplier_mac_pipe #(
  parameter int unsigned A_BIT_LEN       = 17,
  parameter int unsigned B_BIT_LEN       = 17,
  parameter int unsigned MUL_OUT_BIT_LEN = A_BIT_LEN + B_BIT_LEN,
  parameter int unsigned ACC_BIT_LEN     = MUL_OUT_BIT_LEN + 8,
  parameter int unsigned PIPE_STAGES     = 3
) (
  input logic                  clk,
  input logic                  rst,
  multiplier_mac_pipe_if.slave bus
);

  localparam int unsigned ExtW  = A_BIT_LEN + B_BIT_LEN + 2;
  localparam int unsigned ProdW = (MUL_OUT_BIT_LEN > ExtW) ? MUL_OUT_BIT_LEN : ExtW;

  typedef struct packed {
    logic                       valid;
    logic                       sgn;
    logic                       acc_en;
    logic [MUL_OUT_BIT_LEN-1:0] prod;
  } beat_t;

  logic                       adv;
  logic signed [ProdW-1:0]    a_ext;
  logic signed [ProdW-1:0]    b_ext;
  logic signed [ProdW-1:0]    prod_full;
  beat_t                      in_beat;
  beat_t                      last_beat;

  logic                       out_valid_q;
  logic [MUL_OUT_BIT_LEN-1:0] p_q;
  logic [ACC_BIT_LEN-1:0]     acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic [ACC_BIT_LEN-1:0]     ext_prod;
  logic [ACC_BIT_LEN:0]       sum;

  // Whole pipe advances together; it only holds when the output beat is blocked.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // Operands widened with their own sign so one signed multiply is exact in all four modes.
  always_comb begin
    a_ext          = {{(ProdW - A_BIT_LEN){bus.a_signed & bus.A[A_BIT_LEN-1]}}, bus.A};
    b_ext          = {{(ProdW - B_BIT_LEN){bus.b_signed & bus.B[B_BIT_LEN-1]}}, bus.B};
    prod_full      = a_ext * b_ext;
    in_beat.valid  = bus.in_valid;
    in_beat.sgn    = bus.a_signed | bus.b_signed;
    in_beat.acc_en = bus.acc_en;
    in_beat.prod   = prod_full[MUL_OUT_BIT_LEN-1:0];
  end

  // Registers behind the multiplier give synthesis room to retime into DSP pipeline stages.
  if (PIPE_STAGES > 1) begin : g_pipe
    beat_t stg_q [PIPE_STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE_STAGES) - 1; i++) begin
          stg_q[i] <= '0;
        end
      end else if (adv) begin
        stg_q[0] <= in_beat;
        for (int i = 1; i < int'(PIPE_STAGES) - 1; i++) begin
          stg_q[i] <= stg_q[i-1];
        end
      end
    end

    assign last_beat = stg_q[PIPE_STAGES-2];
  end else begin : g_no_pipe
    assign last_beat = in_beat;
  end

  always_comb begin
    ext_prod = ACC_BIT_LEN'({{ACC_BIT_LEN{last_beat.sgn & last_beat.prod[MUL_OUT_BIT_LEN-1]}},
                             last_beat.prod});
    sum      = {1'b0, acc_q} + {1'b0, ext_prod};
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (last_beat.valid) begin
      if (!last_beat.acc_en) begin
        acc_d = ext_prod;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACC_BIT_LEN-1:0];
        if (last_beat.sgn) begin
          ovf_d = ovf_q | ((acc_q[ACC_BIT_LEN-1] == ext_prod[ACC_BIT_LEN-1]) &
                           (sum[ACC_BIT_LEN-1] != acc_q[ACC_BIT_LEN-1]));
        end else begin
          ovf_d = ovf_q | sum[ACC_BIT_LEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= last_beat.valid;
      if (last_beat.valid) begin
        p_q <= last_beat.prod;
      end
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.P         = p_q;
  assign bus.ACC       = acc_q;
  assign bus.acc_ovf   = ovf_q;

endmodule

// File: tb/tb_multiplier_mac_pipe.sv
// Self-checking bench for multiplier_mac_pipe: directed vector table, stall/overflow/reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_multiplier_mac_pipe;

  localparam int AW = 17;
  localparam int BW = 17;
  localparam int PW = AW + BW;
  localparam int CW = PW + 8;
  localparam longint PMASK = (longint'(1) << PW) - 1;
  localparam longint CMASK = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multiplier_mac_pipe_if #(
    .A_BIT_LEN(AW), .B_BIT_LEN(BW), .MUL_OUT_BIT_LEN(PW), .ACC_BIT_LEN(CW)
  ) bus ();

  multiplier_mac_pipe #(
    .A_BIT_LEN(AW), .B_BIT_LEN(BW), .MUL_OUT_BIT_LEN(PW), .ACC_BIT_LEN(CW), .PIPE_STAGES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  typedef struct {
    logic [63:0] p;
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          as;
    logic          bs;
    logic          ae;
    logic [63:0]   p;
    logic [63:0]   acc;
    logic          ovf;
  } vec_t;

  exp_t        sb[$];
  logic [63:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sval(input logic [31:0] v, input int w, input logic s);
    longint x = longint'(v);
    if (s && v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Reference: exact integer product, running sum checked against the representable range.
  task automatic model_push(input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic as, input logic bs, input logic ae);
    longint prod, sum, accs;
    exp_t   e;
    prod = sval(32'(a), AW, as) * sval(32'(b), BW, bs);
    e.p  = prod & PMASK;
    if (!ae) begin
      m_acc = prod & CMASK;
      m_ovf = 1'b0;
    end else if (!(as | bs)) begin
      sum = longint'(m_acc) + prod;
      if (sum > CMASK) m_ovf = 1'b1;
      m_acc = sum & CMASK;
    end else begin
      accs = longint'(m_acc);
      if (m_acc[CW-1]) accs = accs - (longint'(1) << CW);
      sum = accs + prod;
      if (sum >= (longint'(1) << (CW - 1)) || sum < -(longint'(1) << (CW - 1))) m_ovf = 1'b1;
      m_acc = sum & CMASK;
    end
    e.acc = m_acc;
    e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_spurious_beat", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_P", 64'(bus.P), e.p);
          check("sb_ACC", 64'(bus.ACC), e.acc);
          check("sb_ovf", 64'(bus.acc_ovf), 64'(e.ovf));
          n_pop++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        model_push(bus.A, bus.B, bus.a_signed, bus.b_signed, bus.acc_en);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [BW-1:0] b,
                       input logic as, input logic bs, input logic ae);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.a_signed = as;
    bus.b_signed = bs;
    bus.acc_en   = ae;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20; c++) begin
      idle();
      bus.out_ready = 1'b1;
      sample();
      advance();
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tab[10];
    logic [AW-1:0] bp_a[5];
    logic [BW-1:0] bp_b[5];
    int          k, n_out, pop0;
    logic        got;
    logic [63:0] exp_acc;

    tab[0] = '{17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b0, 64'h3FFFC0001, 64'h3FFFC0001, 1'b0};
    tab[1] = '{17'h1FFFF, 17'h00002, 1'b1, 1'b1, 1'b0, 64'h3FFFFFFFE, 64'h3FFFFFFFFFE, 1'b0};
    tab[2] = '{17'h1FFFF, 17'h00002, 1'b0, 1'b0, 1'b0, 64'h00003FFFE, 64'h00003FFFE, 1'b0};
    tab[3] = '{17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0, 1'b0, 64'h3FFFE0001, 64'h3FFFFFE0001, 1'b0};
    tab[4] = '{17'h10000, 17'h10000, 1'b1, 1'b1, 1'b0, 64'h100000000, 64'h100000000, 1'b0};
    tab[5] = '{17'd3, 17'd4, 1'b0, 1'b0, 1'b0, 64'd12, 64'd12, 1'b0};
    tab[6] = '{17'd5, 17'd6, 1'b0, 1'b0, 1'b1, 64'd30, 64'd42, 1'b0};
    tab[7] = '{17'd7, 17'd8, 1'b0, 1'b0, 1'b1, 64'd56, 64'd98, 1'b0};
    tab[8] = '{17'h1FFFF, 17'd5, 1'b1, 1'b1, 1'b1, 64'h3FFFFFFFB, 64'd93, 1'b0};
    tab[9] = '{17'd0, 17'h1FFFF, 1'b1, 1'b1, 1'b1, 64'd0, 64'd93, 1'b0};

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.a_signed  = 1'b0;
    bus.b_signed  = 1'b0;
    bus.acc_en    = 1'b0;
    bus.out_ready = 1'b1;
    advance();
    reset_dut();

    sample();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_P", 64'(bus.P), 64'd0);
    check("rst_ACC", 64'(bus.ACC), 64'd0);
    check("rst_ovf", 64'(bus.acc_ovf), 64'd0);
    advance();

    // Back-to-back vectors; each result must appear exactly three cycles after its beat.
    for (int i = 0; i < 13; i++) begin
      if (i < 10) drive(tab[i].a, tab[i].b, tab[i].as, tab[i].bs, tab[i].ae);
      else idle();
      sample();
      if (i >= 3) begin
        check($sformatf("vec%0d_valid", i - 3), 64'(bus.out_valid), 64'd1);
        check($sformatf("vec%0d_P", i - 3), 64'(bus.P), tab[i-3].p);
        check($sformatf("vec%0d_ACC", i - 3), 64'(bus.ACC), tab[i-3].acc);
        check($sformatf("vec%0d_ovf", i - 3), 64'(bus.acc_ovf), 64'(tab[i-3].ovf));
      end
      advance();
    end
    drain("vec_drain");

    // Backpressure: downstream blocked for six cycles while five beats are offered.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = AW'($urandom);
      bp_b[i] = BW'($urandom);
    end
    pop0 = n_pop;
    k = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (k < 5) drive(bp_a[k], bp_b[k], 1'b0, 1'b0, 1'b1);
      sample();
      if (c >= 3) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        if (sb.size() > 0) begin
          check("stall_P", 64'(bus.P), sb[0].p);
          check("stall_ACC", 64'(bus.ACC), sb[0].acc);
        end
      end
      if (bus.in_valid && bus.in_ready) k++;
      advance();
    end
    check("bp_accepted", 64'(k), 64'd3);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 5 || sb.size() > 0); c++) begin
      if (k < 5) drive(bp_a[k], bp_b[k], 1'b0, 1'b0, 1'b1);
      else idle();
      sample();
      if (bus.in_valid && bus.in_ready) k++;
      advance();
    end
    check("bp_all_out", 64'(n_pop - pop0), 64'd5);
    drain("bp_drain");

    // Unsigned overflow: 256 max products fit in the accumulator, the 257th does not.
    reset_dut();
    n_out = 0;
    exp_acc = (longint'(257) * 64'h3FFFC0001) & CMASK;
    for (int c = 0; c < 262; c++) begin
      if (c < 257) drive(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b1);
      else idle();
      sample();
      if (bus.out_valid) begin
        n_out++;
        if (n_out == 256) check("ovf_beat256", 64'(bus.acc_ovf), 64'd0);
        if (n_out == 257) begin
          check("ovf_beat257", 64'(bus.acc_ovf), 64'd1);
          check("ovf_ACC257", 64'(bus.ACC), exp_acc);
        end
      end
      advance();
    end
    check("ovf_count", 64'(n_out), 64'd257);

    drive(17'd3, 17'd5, 1'b0, 1'b0, 1'b0);
    sample();
    advance();
    idle();
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      sample();
      if (bus.out_valid) begin
        got = 1'b1;
        check("ovf_clear_flag", 64'(bus.acc_ovf), 64'd0);
        check("ovf_clear_ACC", 64'(bus.ACC), 64'd15);
      end
      advance();
    end
    check("ovf_clear_seen", 64'(got), 64'd1);

    // Reset with two beats in flight and a third offered in the reset cycle.
    drive(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b1);
    sample();
    advance();
    drive(17'h00123, 17'h00456, 1'b1, 1'b1, 1'b1);
    sample();
    advance();
    rst = 1'b1;
    drive(17'd2, 17'd2, 1'b0, 1'b0, 1'b0);
    sample();
    advance();
    rst = 1'b0;
    idle();
    sample();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_ACC", 64'(bus.ACC), 64'd0);
    check("midrst_ovf", 64'(bus.acc_ovf), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    advance();
    for (int c = 0; c < 6; c++) begin
      sample();
      check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
      advance();
    end

    // Random traffic with random stalls, sign modes and accumulate restarts.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        drive(($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom),
              ($urandom_range(0, 7) == 0) ? {1'b1, {(BW-1){1'b0}}} : BW'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
      end else begin
        idle();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      sample();
      advance();
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
